// File: rtl/nmr_seq_sram_arb.sv
// Sequence-SRAM arbiter: sequencer port A has absolute priority, host port B uses a REQ/ACK FSM.
// Optional statistics counters are built when SEQ_SRAM_ARB_STAT_EN is defined.
module nmr_seq_sram_arb #(
    parameter int SRAM_ADDR_WIDTH   = 8,
    parameter int SRAM_DAT_WIDTH    = 128,
    parameter int SRAM_BYTEEN_WIDTH = 16,
    parameter int RD_LAT            = 2
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         A_CS,
    input  logic [SRAM_ADDR_WIDTH-1:0]   A_ADDR,
    output logic [SRAM_DAT_WIDTH-1:0]    A_RD_DAT,
    output logic                         A_RD_VLD,
    input  logic                         SEQ_BUSY,
    input  logic                         B_REQ,
    input  logic                         B_WR,
    input  logic [SRAM_ADDR_WIDTH-1:0]   B_ADDR,
    input  logic [SRAM_DAT_WIDTH-1:0]    B_WR_DAT,
    input  logic [SRAM_BYTEEN_WIDTH-1:0] B_BYTEEN,
    output logic                         B_ACK,
    output logic                         B_ERR,
    output logic [SRAM_DAT_WIDTH-1:0]    B_RD_DAT,
    output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
    output logic                         SRAM_CS,
    output logic                         SRAM_CLKEN,
    output logic                         SRAM_WR,
    output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
    output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
    input  logic [SRAM_DAT_WIDTH-1:0]    SRAM_RD_DAT,
    output logic [15:0]                  STAT_STALL_CNT,
    output logic [15:0]                  STAT_BLK_CNT
);

    typedef enum logic [1:0] {
        B_IDLE,
        B_ISSUE,
        B_WAIT,
        B_DONE
    } b_state_t;

    b_state_t                     state;
    logic                         lat_wr;
    logic [SRAM_ADDR_WIDTH-1:0]   lat_addr;
    logic [SRAM_DAT_WIDTH-1:0]    lat_dat;
    logic [SRAM_BYTEEN_WIDTH-1:0] lat_be;

    logic                         b_issue;
    logic                         b_rd_issue;
    logic                         reject;
    logic [RD_LAT-1:0]            tag_a;
    logic [RD_LAT-1:0]            tag_b;
    logic                         b_ret;

    assign b_issue    = (state == B_ISSUE) && !A_CS;
    assign b_rd_issue = b_issue && !lat_wr;
    assign reject     = (state == B_IDLE) && B_REQ && B_WR && SEQ_BUSY;

    assign SRAM_CLKEN = 1'b1;
    assign A_RD_DAT   = SRAM_RD_DAT;
    assign A_RD_VLD   = tag_a[RD_LAT-1];
    assign b_ret      = tag_b[RD_LAT-1];

    // Port A wins combinationally, so the sequencer path sees no added latency.
    always_comb begin
        SRAM_CS     = 1'b0;
        SRAM_ADDR   = '0;
        SRAM_WR     = 1'b0;
        SRAM_WR_DAT = '0;
        SRAM_BYTEEN = '1;
        if (A_CS) begin
            SRAM_CS   = 1'b1;
            SRAM_ADDR = A_ADDR;
        end else if (state == B_ISSUE) begin
            SRAM_CS     = 1'b1;
            SRAM_ADDR   = lat_addr;
            SRAM_WR     = lat_wr;
            SRAM_WR_DAT = lat_dat;
            SRAM_BYTEEN = lat_be;
        end
    end

    // Owner tags travel alongside the SRAM read pipeline; writes push nothing.
    generate
        if (RD_LAT == 1) begin : g_tag_1
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    tag_a <= '0;
                    tag_b <= '0;
                end else begin
                    tag_a <= A_CS;
                    tag_b <= b_rd_issue;
                end
            end
        end else begin : g_tag_n
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    tag_a <= '0;
                    tag_b <= '0;
                end else begin
                    tag_a <= {tag_a[RD_LAT-2:0], A_CS};
                    tag_b <= {tag_b[RD_LAT-2:0], b_rd_issue};
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= B_IDLE;
            lat_wr   <= 1'b0;
            lat_addr <= '0;
            lat_dat  <= '0;
            lat_be   <= '0;
            B_ACK    <= 1'b0;
            B_ERR    <= 1'b0;
            B_RD_DAT <= '0;
        end else begin
            B_ACK <= 1'b0;
            B_ERR <= 1'b0;
            case (state)
                B_IDLE: begin
                    if (B_REQ) begin
                        lat_wr   <= B_WR;
                        lat_addr <= B_ADDR;
                        lat_dat  <= B_WR_DAT;
                        lat_be   <= B_BYTEEN;
                        if (reject) begin
                            state <= B_DONE;
                            B_ACK <= 1'b1;
                            B_ERR <= 1'b1;
                        end else begin
                            state <= B_ISSUE;
                        end
                    end
                end
                B_ISSUE: begin
                    if (b_issue) begin
                        if (lat_wr) begin
                            state <= B_DONE;
                            B_ACK <= 1'b1;
                        end else begin
                            state <= B_WAIT;
                        end
                    end
                end
                B_WAIT: begin
                    if (b_ret) begin
                        B_RD_DAT <= SRAM_RD_DAT;
                        state    <= B_DONE;
                        B_ACK    <= 1'b1;
                    end
                end
                B_DONE: begin
                    state <= B_IDLE;
                end
                default: begin
                    state <= B_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_SRAM_ARB_STAT_EN
    logic [15:0] stall_cnt;
    logic [15:0] blk_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt <= '0;
            blk_cnt   <= '0;
        end else begin
            if ((state == B_ISSUE) && A_CS && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (reject && (blk_cnt != 16'hFFFF)) begin
                blk_cnt <= blk_cnt + 16'd1;
            end
        end
    end

    assign STAT_STALL_CNT = stall_cnt;
    assign STAT_BLK_CNT   = blk_cnt;
`else
    assign STAT_STALL_CNT = '0;
    assign STAT_BLK_CNT   = '0;
`endif

endmodule

// File: doc/nmr_seq_sram_arb.md
# nmr_seq_sram_arb

Arbiter sharing the single-port sequence SRAM (on-chip RAM, 128-bit × 256) between two requesters: the bitstream sequencer, which reads only and must never be delayed, and the host loader, which reads and writes through a REQ/ACK handshake. It sits between both requesters and the SRAM port. It protects the sequence table from host writes while a sequence runs, and tags read returns so each requester gets its own data.

## Interface
- SRAM_ADDR_WIDTH, 8, SRAM address width
- SRAM_DAT_WIDTH, 128, SRAM data width
- SRAM_BYTEEN_WIDTH, 16, SRAM byte-enable width
- RD_LAT, 2, SRAM read latency in cycles, from CS edge to valid SRAM_RD_DAT (≥1)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- A_CS  in  1  sequencer read strobe, one cycle
- A_ADDR  in  SRAM_ADDR_WIDTH  sequencer read address
- A_RD_DAT  out  SRAM_DAT_WIDTH  read data, direct pass-through of SRAM_RD_DAT
- A_RD_VLD  out  1  pulses when A_RD_DAT holds the return for an A_CS
- SEQ_BUSY  in  1  sequence running; host writes rejected while high
- B_REQ  in  1  host request (level)
- B_WR  in  1  1 = write, 0 = read
- B_ADDR  in  SRAM_ADDR_WIDTH  host address
- B_WR_DAT  in  SRAM_DAT_WIDTH  host write data
- B_BYTEEN  in  SRAM_BYTEEN_WIDTH  host byte enables
- B_ACK  out  1  one-cycle transaction completion
- B_ERR  out  1  valid with B_ACK; 1 = write rejected
- B_RD_DAT  out  SRAM_DAT_WIDTH  registered host read data, held until the next host read
- SRAM_ADDR, SRAM_CS, SRAM_CLKEN, SRAM_WR, SRAM_WR_DAT, SRAM_BYTEEN  out  SRAM port drive
- SRAM_RD_DAT  in  SRAM_DAT_WIDTH  SRAM read data
- STAT_STALL_CNT  out  16  host-stall cycle count (see Configuration)
- STAT_BLK_CNT  out  16  rejected-write count (see Configuration)

## Operation
- Port A has fixed absolute priority. When A_CS=1, SRAM_CS=1, SRAM_ADDR=A_ADDR, SRAM_WR=0, all in the same cycle through a combinational mux. This adds zero latency to the sequencer path.
- SRAM_CLKEN is constant 1. When A owns the port or the port is idle: SRAM_WR_DAT=0 and SRAM_BYTEEN=all ones.
- Host FSM states:
  - B_IDLE: on B_REQ=1, latch B_WR, B_ADDR, B_WR_DAT and B_BYTEEN. If B_WR=1 and SEQ_BUSY=1, set err and go to B_DONE. Otherwise go to B_ISSUE.
  - B_ISSUE: if A_CS=1, stay here; this is a stall cycle. If A_CS=0, drive SRAM_CS=1 and SRAM_ADDR from the latch, with SRAM_WR, SRAM_WR_DAT and SRAM_BYTEEN also from the latch. A write then goes to B_DONE; a read goes to B_WAIT.
  - B_WAIT: wait for the host-tagged return. Capture SRAM_RD_DAT into B_RD_DAT, then go to B_DONE.
  - B_DONE: B_ACK=1 and B_ERR=err for one cycle, then go to B_IDLE.
- SEQ_BUSY is sampled only in B_IDLE. A write already in B_ISSUE completes even if SEQ_BUSY rises during the stall.
- Host reads are allowed in every state of SEQ_BUSY.
- Return tagging: an RD_LAT-deep shift register of {a, b} tag bits, loaded each cycle with the current issue owner. The tag at the output stage drives A_RD_VLD, or the B capture. Writes push no tag.
- Requester rule: hold B_REQ until B_ACK is seen, and deassert it in the cycle after B_ACK. B_REQ high in B_IDLE starts a new transaction.

## Timing
- Reset values: B_ACK=0, B_ERR=0, B_RD_DAT=0, A_RD_VLD=0, tag pipe cleared, FSM=B_IDLE, stats=0.
- Reset mid-transaction: the transaction is dropped with no ACK. A write in B_ISSUE that has not yet been driven does not happen.
- A read: A_CS at cycle t gives A_RD_VLD at t+RD_LAT.
- Host read, unstalled: REQ sampled at edge e. Issue in cycle e+1, capture at e+1+RD_LAT, B_ACK one cycle later. With RD_LAT=2, B_ACK is asserted 4 cycles after REQ is sampled.
- Host write, unstalled: B_ACK asserted 2 cycles after REQ is sampled.
- Rejected write: B_ACK with B_ERR=1 asserted 1 cycle after REQ is sampled; no SRAM access.
- Each A_CS cycle during B_ISSUE adds exactly one cycle of latency.
- A_CS asserted in the same cycle as a pending host read is safe. The tags keep the two returns distinct, and there is never more than one owner per cycle.

## Configuration
- SEQ_SRAM_ARB_STAT_EN defined:
  - STAT_STALL_CNT increments on each B_ISSUE cycle with A_CS=1.
  - STAT_BLK_CNT increments on each rejected write.
  - Both counters saturate at 0xFFFF and clear only on reset.
- Not defined: both ports are driven constant 0, and no counter logic is generated. The port list is identical in both builds.

## Test plan
- Host write to addr 0x05 (data 0x…AA, BYTEEN=0xFFFF, SEQ_BUSY=0), then host read of 0x05 → first B_ACK 2 cycles after REQ with B_ERR=0; read B_ACK 4 cycles after REQ with B_RD_DAT=0x…AA.
- SEQ_BUSY=1, host write to 0x05 → B_ACK+B_ERR=1 after 1 cycle; SRAM_CS never asserted; STAT_BLK_CNT=1 when the macro is defined, 0 otherwise.
- Host read pending while A_CS is pulsed 3 consecutive cycles at addr 0x01 → host ACK delayed exactly 3 cycles; three A_RD_VLD pulses, each at A_CS+2; B_RD_DAT is the host address's data, not 0x01's.
- A_CS at cycle t interleaved with a host read issued at t+1 → A_RD_VLD at t+2; host capture at t+3; no cross-delivery.
- RST_N asserted while in B_WAIT → outputs return to reset values at once; no B_ACK; next B_REQ serviced normally.
